// File: rtl/usb_tx_sequencer.sv
// Buffers 8-bit ADC samples, frames them behind a sync byte and paces each
// byte into an FT232H-style synchronous FIFO via txe_n, driving fifo_driver.
//
// state   | meaning
// S_IDLE  | waiting for enable and a buffered byte (code 0)
// S_LOAD  | tx_data stable, waiting for txe_n low (code 0)
// S_WRITE | wr low for one cycle, byte offered (code 1)
// S_HOLD  | wr high recovery cycle after an accepted byte (code 2)
module usb_tx_sequencer #(
  parameter int          DEPTH     = 16,
  parameter int          FRAME_LEN = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        txe_n,
  output logic [1:0]  state,
  output logic [7:0]  tx_data,
  output logic [15:0] overflow_count,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_HOLD} fsm_t;

  fsm_t          fsm;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    frame_pos;
  logic          full;
  logic          push;
  logic          pop;
  logic          last_in_frame;

  assign full          = (count == (AW+1)'(DEPTH));
  assign sample_ready  = !full;
  assign push          = sample_valid && !full;
  // Only data bytes consume buffer entries; the sync byte is synthesized.
  assign pop           = (fsm == S_WRITE) && !txe_n && (frame_pos != 8'd0);
  assign last_in_frame = (frame_pos == 8'(FRAME_LEN));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_count <= '0;
    end else if (sample_valid && full && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      state     <= 2'd0;
      busy      <= 1'b0;
      tx_data   <= 8'h00;
      frame_pos <= 8'd0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (enable && (count != '0)) begin
            tx_data <= (frame_pos == 8'd0) ? SYNC_BYTE : mem[rd_ptr];
            fsm     <= S_LOAD;
            state   <= 2'd0;
            busy    <= 1'b1;
          end else if (!enable) begin
            frame_pos <= 8'd0;
          end
        end
        S_LOAD: begin
          if (!txe_n) begin
            fsm   <= S_WRITE;
            state <= 2'd1;
          end
        end
        S_WRITE: begin
          if (!txe_n) begin
            frame_pos <= last_in_frame ? 8'd0 : frame_pos + 8'd1;
            fsm       <= S_HOLD;
            state     <= 2'd2;
          end else begin
            // Rejected by the FIFO: re-present the same byte.
            fsm   <= S_LOAD;
            state <= 2'd0;
          end
        end
        S_HOLD: begin
          fsm   <= S_IDLE;
          state <= 2'd0;
          busy  <= 1'b0;
        end
        default: begin
          fsm   <= S_IDLE;
          state <= 2'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: framing, flow control, retry,
// overflow and mid-write reset, with a byte-stream reference model.
module tb_usb_tx_sequencer;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        txe_n;
  logic [1:0]  state;
  logic [7:0]  tx_data;
  logic [15:0] overflow_count;
  logic        busy;

  logic [7:0] acc[$];
  logic [7:0] exp_q[$];
  logic [1:0] trace[$];
  logic       trace_en = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         wr_cycles = 0;
  int         model_pos = 0;
  int         n_rdy;

  usb_tx_sequencer #(.DEPTH(16), .FRAME_LEN(FL), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .txe_n(txe_n), .state(state),
    .tx_data(tx_data), .overflow_count(overflow_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte acceptance is decided at the next rising edge by txe_n, which is stable here.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (trace_en) trace.push_back(state);
      if (state == 2'd1) begin
        wr_cycles++;
        if (!txe_n) acc.push_back(tx_data);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_push(input logic [7:0] d);
    if (model_pos == 0) begin
      exp_q.push_back(8'hA5);
      model_pos = 1;
    end
    exp_q.push_back(d);
    model_pos = (model_pos == FL) ? 0 : model_pos + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = 8'h00; txe_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    acc.delete(); exp_q.delete();
    wr_cycles = 0; model_pos = 0;
  endtask

  task automatic push_one(input logic [7:0] d, input bit model);
    sample_valid = 1'b1; sample_data = d;
    if (model) model_push(d);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("acc_count", acc.size(), n);
  endtask

  task automatic wait_state(input logic [1:0] code, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (state != code && k < budget);
    chk("wait_state", state, code);
  endtask

  task automatic compare_acc();
    chk("acc_len", acc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < acc.size()) chk($sformatf("byte%0d", i), acc[i], exp_q[i]);
  endtask

  initial begin
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ovf", overflow_count, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_busy", busy, 0);

    // Three samples with free-flowing FIFO
    enable = 1'b1; txe_n = 1'b0; trace_en = 1'b1;
    sample_valid = 1'b1;
    sample_data = 8'h10; model_push(8'h10); tick();
    sample_data = 8'h11; model_push(8'h11); tick();
    sample_data = 8'h12; model_push(8'h12); tick();
    sample_valid = 1'b0;
    wait_acc(4, 60);
    trace_en = 1'b0;
    compare_acc();
    chk("t1_latency_write", trace[3], 2'd1);
    chk("t1_hold", trace[4], 2'd2);
    chk("t1_idle_after", trace[5], 2'd0);
    chk("t1_next_write", trace[7], 2'd1);
    repeat (4) tick();
    chk("t1_busy_end", busy, 0);
    chk("t1_ready_end", sample_ready, 1);
    chk("t1_no_extra", acc.size(), 4);

    // Framing with FRAME_LEN=4 over nine samples
    do_reset();
    enable = 1'b1; txe_n = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      sample_valid = 1'b1; sample_data = 8'(i); model_push(8'(i)); tick();
    end
    sample_valid = 1'b0;
    wait_acc(12, 200);
    repeat (8) tick();
    compare_acc();

    // txe_n held high in LOAD
    do_reset();
    enable = 1'b1; txe_n = 1'b1;
    push_one(8'h33, 1'b1);
    repeat (10) tick();
    chk("t3_state_load", state, 0);
    chk("t3_tx_data_held", tx_data, 8'hA5);
    chk("t3_no_write", wr_cycles, 0);
    chk("t3_busy", busy, 1);
    txe_n = 1'b0;
    wait_acc(2, 50);
    repeat (4) tick();
    compare_acc();
    chk("t3_writes", wr_cycles, 2);

    // txe_n rises during WRITE -> retry
    do_reset();
    enable = 1'b1; txe_n = 1'b0;
    push_one(8'h44, 1'b1);
    wait_state(2'd1, 20);
    txe_n = 1'b1;
    tick();
    chk("t4_back_to_load", state, 0);
    chk("t4_data_kept", tx_data, 8'hA5);
    tick(); tick();
    chk("t4_rejected_cnt", wr_cycles, 1);
    chk("t4_nothing_acc", acc.size(), 0);
    txe_n = 1'b0;
    wait_acc(2, 50);
    repeat (4) tick();
    compare_acc();
    chk("t4_writes", wr_cycles, 3);

    // Buffer overflow with FIFO blocked
    do_reset();
    enable = 1'b1; txe_n = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1; sample_data = 8'h20 + 8'(i);
      if (sample_ready) begin
        n_rdy++;
        model_push(sample_data);
      end
      tick();
    end
    sample_valid = 1'b0;
    chk("t5_accepted", n_rdy, 16);
    chk("t5_ovf", overflow_count, 4);
    chk("t5_ready_low", sample_ready, 0);
    txe_n = 1'b0;
    wait_acc(20, 300);
    repeat (4) tick();
    compare_acc();
    chk("t5_ready_after", sample_ready, 1);
    chk("t5_busy_after", busy, 0);

    // Reset during WRITE
    do_reset();
    enable = 1'b1; txe_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sample_valid = 1'b1; sample_data = 8'h50 + 8'(i); tick();
    end
    sample_valid = 1'b0;
    chk("t6_ovf_pre", overflow_count, 2);
    txe_n = 1'b0;
    wait_state(2'd1, 20);
    rst = 1'b1;
    #1;
    chk("t6_state", state, 0);
    chk("t6_tx_data", tx_data, 8'h00);
    chk("t6_ready", sample_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_ovf", overflow_count, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    acc.delete(); exp_q.delete(); wr_cycles = 0; model_pos = 0;
    repeat (8) tick();
    chk("t6_buffer_empty", acc.size(), 0);
    chk("t6_idle", busy, 0);
    push_one(8'h60, 1'b1);
    wait_acc(2, 50);
    compare_acc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
- Sits directly upstream of fifo_driver. Buffers 8-bit ADC samples and frames them with a sync byte.
- Paces each byte into the FT232H-style synchronous FIFO using the txe_n flow-control pin.
- Produces the 2-bit state code and data byte consumed by fifo_driver: code 0 = wr high, data passes through; code 1 = wr low, data held; code 2 = wr high, data passes through.

Parameters:
- DEPTH, 16, sample buffer entries; power of 2, at least 4.
- FRAME_LEN, 64, data bytes per frame following each sync byte; range 1..255.
- SYNC_BYTE, 8'hA5, frame header value.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  streaming enable.
- sample_data  in  8  ADC sample.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_ready  out  1  buffer can accept; a push occurs when sample_valid && sample_ready.
- txe_n  in  1  FT232H transmit-empty, active low; low means the FIFO has room.
- state  out  2  code to fifo_driver (0/1/2 as above).
- tx_data  out  8  byte to fifo_driver data_in.
- overflow_count  out  16  saturating count of cycles with sample_valid && !sample_ready.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values:
  - FSM in IDLE, so state = 0.
  - tx_data = 8'h00; overflow_count = 0; frame_pos = 0; buffer empty.
  - sample_ready = 1; busy = 0.
- Buffer:
  - Circular FIFO with DEPTH entries, registered read/write pointers plus count.
  - sample_ready = !full. It uses the current-cycle full flag only, so a pop in the same cycle does not admit a push when full.
  - Push and pop in the same cycle when not full: count unchanged.
- Frame counter frame_pos (0..FRAME_LEN):
  - frame_pos = 0 means the next byte is SYNC_BYTE; otherwise the next byte is the buffer head.
  - A sync is only started when the buffer is non-empty.
- FSM: four internal states; state output is registered from the FSM state.
  - IDLE (code 0):
    - If enable && buffer non-empty: tx_data <= (frame_pos==0 ? SYNC_BYTE : head); go to LOAD.
    - Otherwise stay. The buffer is not popped here.
  - LOAD (code 0):
    - tx_data is stable so fifo_driver passes it through.
    - If txe_n==0, go to WRITE; otherwise stay in LOAD.
  - WRITE (code 1): wr is low for exactly one cycle.
    - If txe_n==0 at the closing edge, the byte is accepted:
      - If it was a data byte, pop the buffer.
      - frame_pos <= (frame_pos==FRAME_LEN) ? 0 : frame_pos+1.
      - Go to HOLD.
    - If txe_n==1, the byte is not accepted: no pop, tx_data unchanged, go back to LOAD (retry).
  - HOLD (code 2): one cycle with wr high; go to IDLE.
- tx_data changes only on the IDLE→LOAD transition and is held through LOAD, WRITE and HOLD.
- Throughput: 4 cycles per byte when txe_n stays low.
- Latency from the first push into an empty buffer (frame_pos≠0) to WRITE: 3 cycles.
- enable deasserted:
  - A byte already in LOAD/WRITE/HOLD completes, including retries.
  - Once in IDLE, no new byte starts, and frame_pos is cleared to 0 so the next stream begins with sync.
  - The buffer keeps accepting pushes and is not flushed.
- overflow_count increments on each cycle with sample_valid && !sample_ready, saturating at 16'hFFFF.
- Async reset mid-operation: state returns to 0 immediately and the partially sent byte is discarded; the buffer is emptied.

Test Plan:
- Reset, enable=1, txe_n=0, push 3 samples 8'h10/11/12 → byte sequence at WRITE-accept is A5,10,11,12; state follows 0,0,1,2 per byte; buffer empty and busy=0 afterwards.
- FRAME_LEN=4, push 9 samples 1..9 continuously → accepted stream A5,1,2,3,4,A5,5,6,7,8,A5,9.
- txe_n held high during LOAD for 10 cycles, then low → state stays 0 with tx_data constant, then exactly one WRITE; no duplicated or lost byte.
- txe_n rises during WRITE → no pop, returns to LOAD with the same tx_data, retry succeeds when txe_n=0 → byte appears once.
- txe_n=1, push 20 samples with DEPTH=16 → sample_ready drops after 16 pushes, overflow_count=4; after release, the 16 buffered bytes are sent in order.
- Assert rst during WRITE → state=0, tx_data=00, buffer empty, overflow_count=0 immediately; after release, the next stream starts with A5.
